// File: rtl/pe_context_sequencer_pkg.sv
// Shared types, field layout and defaults for the processing-element context sequencer.
package pe_context_sequencer_pkg;

    localparam int unsigned CTX_DEPTH_DEF = 16;
    localparam int unsigned CTX_WIDTH_DEF = 16;
    localparam int unsigned ADDR_W        = 4;
    localparam int unsigned II_W          = 5;
    localparam int unsigned ITER_W        = 16;
    localparam int unsigned OP_W          = 6;
    localparam int unsigned SEL_W         = 2;

    // Context word layout; bits above FIELD_W-1 are reserved.
    localparam int unsigned FIELD_W  = 12;
    localparam int unsigned OP_LSB   = 0;
    localparam int unsigned LHS_LSB  = 6;
    localparam int unsigned RHS_LSB  = 8;
    localparam int unsigned PRED_BIT = 10;
    localparam int unsigned OUT_BIT  = 11;

    localparam logic [OP_W-1:0] ALU_NOP = 6'b000000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [SEL_W-1:0] lhs_sel;
        logic [SEL_W-1:0] rhs_sel;
        logic             pred_en;
        logic             out_en;
    } ctx_t;

    localparam ctx_t CTX_IDLE = '{op: ALU_NOP, lhs_sel: '0, rhs_sel: '0, pred_en: 1'b0, out_en: 1'b0};

    function automatic ctx_t decode_ctx(input logic [FIELD_W-1:0] w);
        ctx_t c;
        c.op      = w[OP_LSB +: OP_W];
        c.lhs_sel = w[LHS_LSB +: SEL_W];
        c.rhs_sel = w[RHS_LSB +: SEL_W];
        c.pred_en = w[PRED_BIT];
        c.out_en  = w[OUT_BIT];
        return c;
    endfunction

endpackage

// File: rtl/pe_context_mem.sv
// Context store: one synchronous write port, one combinational read port; never cleared.
module pe_context_mem
    import pe_context_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = CTX_DEPTH_DEF,
    parameter int unsigned WIDTH = CTX_WIDTH_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pe_context_sequencer.sv
// Issues stored contexts to the PE ALU in a modulo-ii loop for a programmed iteration count.
module pe_context_sequencer
    import pe_context_sequencer_pkg::*;
#(
    parameter int unsigned CTX_DEPTH = CTX_DEPTH_DEF,
    parameter int unsigned CTX_WIDTH = CTX_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_we,
    input  logic [ADDR_W-1:0]    cfg_addr,
    input  logic [CTX_WIDTH-1:0] cfg_data,
    input  logic                 start,
    input  logic [II_W-1:0]      ii,
    input  logic [ITER_W-1:0]    iter_count,
    input  logic                 stall,
    input  logic                 abort,
    output logic [OP_W-1:0]      alu_operation,
    output logic [SEL_W-1:0]     lhs_sel,
    output logic [SEL_W-1:0]     rhs_sel,
    output logic                 pred_en,
    output logic                 out_en,
    output logic                 ctx_valid,
    output logic [ADDR_W-1:0]    pc,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err
);

    state_t               state_q, state_d;
    logic [II_W-1:0]      ii_q;
    logic [ITER_W-1:0]    iter_lim_q, iter_cnt_q, iter_cnt_d;
    logic [ADDR_W-1:0]    pc_d;
    logic [CTX_WIDTH-1:0] rd_data;
    ctx_t                 ctx_rd_c, ctx_q, ctx_d;
    logic                 valid_d, busy_d, done_d, cfg_err_d;
    logic                 start_ok_c, launch_c, advance_c, last_c, finish_c, mem_we_c;
    logic                 unused_rd_c;

    assign start_ok_c  = start && (ii != '0) && (32'(ii) <= CTX_DEPTH);
    assign launch_c    = (state_q != ST_RUN) && !abort && start_ok_c;
    assign advance_c   = (state_q == ST_RUN) && !abort && !stall;
    assign last_c      = ({1'b0, pc} == ii_q - II_W'(1));
    assign finish_c    = advance_c && last_c && (iter_lim_q != '0)
                         && (iter_cnt_q == iter_lim_q - ITER_W'(1));
    assign mem_we_c    = cfg_we && (state_q != ST_RUN);
    assign ctx_rd_c    = decode_ctx(rd_data[FIELD_W-1:0]);
    assign unused_rd_c = ^rd_data[CTX_WIDTH-1:FIELD_W];

    // Read address is the pc of the next cycle so the issued fields can be registered.
    pe_context_mem #(
        .DEPTH (CTX_DEPTH),
        .WIDTH (CTX_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_c),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr (pc_d),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (launch_c) state_d = ST_RUN;
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (finish_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = launch_c ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of pc, iteration counter and every registered output.
    always_comb begin
        pc_d       = '0;
        iter_cnt_d = iter_cnt_q;
        ctx_d      = CTX_IDLE;
        valid_d    = 1'b0;
        busy_d     = (state_d == ST_RUN);
        done_d     = (state_d == ST_DONE);
        cfg_err_d  = (cfg_we && (state_q == ST_RUN))
                     || (start && !start_ok_c && (state_q != ST_RUN) && !abort);
        if (launch_c) begin
            iter_cnt_d = '0;
            ctx_d      = ctx_rd_c;
            valid_d    = 1'b1;
        end else if (state_d == ST_RUN) begin
            if (advance_c) begin
                pc_d    = last_c ? '0 : pc + ADDR_W'(1);
                ctx_d   = ctx_rd_c;
                valid_d = 1'b1;
                if (last_c) begin
                    iter_cnt_d = iter_cnt_q + ITER_W'(1);
                end
            end else begin
                pc_d  = pc;
                ctx_d = ctx_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= '0;
            iter_cnt_q <= '0;
            ii_q       <= '0;
            iter_lim_q <= '0;
            ctx_q      <= CTX_IDLE;
            ctx_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            pc         <= pc_d;
            iter_cnt_q <= iter_cnt_d;
            ctx_q      <= ctx_d;
            ctx_valid  <= valid_d;
            busy       <= busy_d;
            done       <= done_d;
            cfg_err    <= cfg_err_d;
            if (launch_c) begin
                ii_q       <= ii;
                iter_lim_q <= iter_count;
            end
        end
    end

    assign alu_operation = ctx_q.op;
    assign lhs_sel       = ctx_q.lhs_sel;
    assign rhs_sel       = ctx_q.rhs_sel;
    assign pred_en       = ctx_q.pred_en;
    assign out_en        = ctx_q.out_en;

endmodule

// File: tb/tb_pe_context_sequencer.sv
// Self-checking bench for pe_context_sequencer against a flat issue-position reference model.
module tb_pe_context_sequencer;

    localparam int unsigned DEPTH   = 16;
    localparam int          MAX_CYC = 400;

    logic        clk = 1'b0;
    logic        reset, cfg_we, start, stall, abort;
    logic [3:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic [4:0]  ii;
    logic [15:0] iter_count;
    logic [5:0]  alu_operation;
    logic [1:0]  lhs_sel, rhs_sel;
    logic        pred_en, out_en, ctx_valid, busy, done, cfg_err;
    logic [3:0]  pc;
    logic [19:0] obs;

    logic [15:0] ctx_m [DEPTH];
    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    pe_context_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_data      (cfg_data),
        .start         (start),
        .ii            (ii),
        .iter_count    (iter_count),
        .stall         (stall),
        .abort         (abort),
        .alu_operation (alu_operation),
        .lhs_sel       (lhs_sel),
        .rhs_sel       (rhs_sel),
        .pred_en       (pred_en),
        .out_en        (out_en),
        .ctx_valid     (ctx_valid),
        .pc            (pc),
        .busy          (busy),
        .done          (done),
        .cfg_err       (cfg_err)
    );

    assign obs = {busy, done, cfg_err, ctx_valid, pc, alu_operation, lhs_sel, rhs_sel, pred_en, out_en};

    // Expected bundle while running: fields sliced straight from the stored context word.
    function automatic logic [19:0] exp_run(input int p, input bit v, input bit err);
        logic [15:0] w;
        w = ctx_m[p];
        return {1'b1, 1'b0, err, v, 4'(p), w[5:0], w[7:6], w[9:8], w[10], w[11]};
    endfunction

    function automatic logic [19:0] exp_idle(input bit d, input bit err);
        return {1'b0, d, err, 17'd0};
    endfunction

    task automatic write_ctx(input int a, input logic [15:0] d);
        cfg_we   = 1'b1;
        cfg_addr = 4'(a);
        cfg_data = d;
        ctx_m[a] = d;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic load_program(input bit random_ops);
        for (int i = 0; i < int'(DEPTH); i++) begin
            logic [15:0] r;
            r = 16'($urandom);
            if (!random_ops && i < 3) r[5:0] = 6'(i + 1);
            write_ctx(i, r);
        end
    endtask

    // Runs one program; the model tracks a flat issue position over ii*n_iter contexts.
    task automatic run_case(input string name, input int n_ii, input int n_iter,
                            input int stall_pct, input int st_from, input int st_len,
                            input int abort_at, input int we_at, output int done_cyc);
        int pos, c, total;
        bit prev_st, st, ab, fin, aborted;
        logic [19:0] exp;
        total    = n_ii * n_iter;
        pos      = 0;
        c        = 1;
        prev_st  = 1'b0;
        fin      = 1'b0;
        aborted  = 1'b0;
        done_cyc = -1;
        start      = 1'b1;
        ii         = 5'(n_ii);
        iter_count = 16'(n_iter);
        @(negedge clk);
        start = 1'b0;
        while (!fin) begin
            if (c > MAX_CYC) begin
                n_total++;
                $display("FAIL %s timeout: still running after %0d cycles, required done", name, c);
                break;
            end
            exp = exp_run(pos % n_ii, (c == 1) || !prev_st, c == we_at + 1);
            n_total++;
            if (obs !== exp) $display("FAIL %s cycle %0d: got %h expected %h", name, c, obs, exp);
            else n_pass++;
            st = ((stall_pct > 0) && ($urandom_range(99) < 32'(stall_pct)))
                 || (c >= st_from && c < st_from + st_len);
            ab = (c == abort_at);
            stall  = st;
            abort  = ab;
            cfg_we = (c == we_at);
            if (c == we_at) begin
                cfg_addr = 4'd1;
                cfg_data = 16'($urandom);
            end
            @(negedge clk);
            stall  = 1'b0;
            abort  = 1'b0;
            cfg_we = 1'b0;
            c++;
            if (ab) begin
                fin     = 1'b1;
                aborted = 1'b1;
            end else if (!st) begin
                if (total != 0 && pos == total - 1) begin
                    fin      = 1'b1;
                    done_cyc = c;
                end else begin
                    pos++;
                end
            end
            prev_st = st;
        end
        exp = exp_idle(!aborted, c == we_at + 1);
        n_total++;
        if (obs !== exp) $display("FAIL %s end cycle %0d: got %h expected %h", name, c, obs, exp);
        else n_pass++;
        @(negedge clk);
        exp = exp_idle(1'b0, 1'b0);
        n_total++;
        if (obs !== exp) $display("FAIL %s idle after end: got %h expected %h", name, obs, exp);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        n_total++;
        if (obs !== 20'd0) $display("FAIL reset_outputs: got %h expected %h", obs, 20'd0);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_program();
        int d;
        load_program(1'b0);
        run_case("program", 3, 2, 0, 0, 0, -1, -5, d);
        n_total++;
        if (d !== 7) $display("FAIL program_done_cycle: got %0d expected %0d", d, 7);
        else n_pass++;
    endtask

    task automatic test_stall();
        int d;
        run_case("stall", 3, 2, 0, 2, 2, -1, -5, d);
        n_total++;
        if (d !== 9) $display("FAIL stall_done_cycle: got %0d expected %0d", d, 9);
        else n_pass++;
    endtask

    task automatic test_abort();
        int d;
        run_case("abort", 2, 0, 0, 0, 0, 10, -5, d);
    endtask

    task automatic test_bad_start();
        logic [19:0] exp;
        for (int k = 0; k < 2; k++) begin
            start = 1'b1;
            ii    = (k == 0) ? 5'd0 : 5'd17;
            iter_count = 16'd3;
            @(negedge clk);
            start = 1'b0;
            exp = exp_idle(1'b0, 1'b1);
            n_total++;
            if (obs !== exp) $display("FAIL bad_start_%0d: got %h expected %h", k, obs, exp);
            else n_pass++;
        end
        @(negedge clk);
        exp = exp_idle(1'b0, 1'b0);
        n_total++;
        if (obs !== exp) $display("FAIL bad_start_quiet: got %h expected %h", obs, exp);
        else n_pass++;
    endtask

    task automatic test_cfg_in_run();
        int d;
        run_case("cfg_in_run", 3, 3, 0, 0, 0, -1, 2, d);
    endtask

    task automatic test_reset_mid_run();
        logic [19:0] exp;
        int d;
        start = 1'b1;
        ii    = 5'd3;
        iter_count = 16'd0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            exp = exp_run(c, 1'b1, 1'b0);
            n_total++;
            if (obs !== exp) $display("FAIL reset_run_pc%0d: got %h expected %h", c, obs, exp);
            else n_pass++;
            if (c < 2) @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_total++;
        if (obs !== 20'd0) $display("FAIL reset_mid_run: got %h expected %h", obs, 20'd0);
        else n_pass++;
        run_case("rerun_after_reset", 3, 2, 0, 0, 0, -1, -5, d);
    endtask

    task automatic test_back_to_back();
        logic [19:0] exp;
        start = 1'b1;
        ii    = 5'd2;
        iter_count = 16'd1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 2; c++) begin
            exp = exp_run(c, 1'b1, 1'b0);
            n_total++;
            if (obs !== exp) $display("FAIL b2b_first_pc%0d: got %h expected %h", c, obs, exp);
            else n_pass++;
            @(negedge clk);
        end
        exp = exp_idle(1'b1, 1'b0);
        n_total++;
        if (obs !== exp) $display("FAIL b2b_done: got %h expected %h", obs, exp);
        else n_pass++;
        start = 1'b1;
        ii    = 5'd3;
        iter_count = 16'd1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            exp = exp_run(c, 1'b1, 1'b0);
            n_total++;
            if (obs !== exp) $display("FAIL b2b_second_pc%0d: got %h expected %h", c, obs, exp);
            else n_pass++;
            @(negedge clk);
        end
        exp = exp_idle(1'b1, 1'b0);
        n_total++;
        if (obs !== exp) $display("FAIL b2b_second_done: got %h expected %h", obs, exp);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_boundaries();
        int d;
        run_case("ii_one", 1, 5, 30, 0, 0, -1, -5, d);
        run_case("ii_max", 16, 1, 0, 0, 0, -1, -5, d);
    endtask

    task automatic test_random();
        int d, n_ii, n_it, ab;
        for (int r = 0; r < 6; r++) begin
            load_program(1'b1);
            n_ii = int'($urandom_range(1, 16));
            n_it = int'($urandom_range(0, 4));
            ab   = (n_it == 0) ? int'($urandom_range(5, 40)) : -1;
            run_case("random", n_ii, n_it, 25, 0, 0, ab, -5, d);
        end
    endtask

    initial begin
        reset      = 1'b0;
        cfg_we     = 1'b0;
        cfg_addr   = '0;
        cfg_data   = '0;
        start      = 1'b0;
        ii         = '0;
        iter_count = '0;
        stall      = 1'b0;
        abort      = 1'b0;
        @(negedge clk);
        test_reset();
        test_program();
        test_stall();
        test_abort();
        test_bad_start();
        test_cfg_in_run();
        test_reset_mid_run();
        test_back_to_back();
        test_boundaries();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
